pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It generalises the team's combinational generate-loop ripple subtractor to WIDTH bits split into STAGES ripple chunks, with a registered carry between chunks. Add/subtract is selectable per operation, and valid/ready handshakes sit on both sides. It is used wherever a wide add or subtract must meet timing at clk and tolerate downstream back-pressure.

Parameters:
WIDTH, 32, operand/result width in bits.
STAGES, 4, pipeline stages and number of ripple chunks. Must satisfy WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH; elaboration-time error otherwise.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept an operand beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; for subtract this is the reference "bin" bit, and 1 gives a true a-b.
mode  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+cin).
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts the result this cycle.
result  output  WIDTH  sum/difference modulo 2^WIDTH.
cout  output  1  raw carry out of MSB; in subtract mode cout=1 means no borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, result 0, cout 0, ovf 0. All internal chunk and carry registers are 0.
- Chunk width: CW = WIDTH/STAGES.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of A and of B', where B' = mode ? ~b : b.
  - Carry-in for stage 0 is cin; for stage k>0 it is the carry registered by stage k-1.
  - Low chunks already computed and high operand chunks not yet consumed travel forward in skew registers alongside.
- Latency: a beat accepted at edge N (in_valid & in_ready) presents out_valid=1 with its result after edge N+STAGES, assuming no stall.
- Throughput: one beat per cycle when out_ready=1.
- Stall rule: advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance=0, every pipeline register (data, carries, valid bits) holds.
  - The pipeline moves as one unit; bubbles are not compressed.
- Output hold: while out_valid=1 and out_ready=0, result/cout/ovf stay stable.
- Bubbles: in_valid=0 while in_ready=1 inserts a bubble (stage valid 0). Data registers may update freely under a bubble; only valid bits gate output.
- Simultaneous accept and drain is legal: the new beat enters stage 0 while the oldest leaves.
- Overflow (ovf): computed in the final stage from the MSB chunk's internal carry into bit WIDTH-1 and cout. It is meaningful for both modes. In subtract mode with cin=0 the result is a-b-1.
- STAGES=1: single registered ripple adder, latency 1.
- STAGES=WIDTH: 1-bit chunks, latency WIDTH.
- Reset mid-operation: all in-flight beats are discarded and no partial result emerges. The first beat after rst deasserts follows normal latency.
- Width rules: result is truncated to WIDTH bits, with no sign extension. mode is sampled with its operands and travels with the beat, so a mode change between consecutive beats is legal.

Decomposition:
- Shared package addsub_pkg:
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - helper function for chunk-slice index arithmetic.
- Sub-module addsub_chunk (parameter CW):
  - Combinational CW-bit ripple of full-adder cells built with a generate loop.
  - Outputs the sum chunk, carry out, and carry into its MSB (used for ovf in the top chunk).
- Top level: instantiates STAGES chunks plus the skew/valid registers and the stall logic.

Test Plan:
All scenarios use WIDTH=32, STAGES=4.
1. Add across chunk boundaries: mode=0, a=0x0000_00FF, b=0x0000_0001, cin=0 -> 4 cycles later result=0x0000_0100, cout=0, ovf=0. Repeat with a=0xFFFF_FFFF, b=1 -> result=0, cout=1, ovf=0.
2. Subtract: mode=1, a=100, b=20, cin=1 -> result=80, cout=1. Then a=5, b=7, cin=1 -> result=0xFFFF_FFFE, cout=0 (borrow), ovf=0.
3. Signed overflow:
   - add 0x7FFF_FFFF + 1 -> result=0x8000_0000, ovf=1.
   - sub 0x8000_0000 - 1 (cin=1) -> result=0x7FFF_FFFF, ovf=1.
4. Back-pressure: stream 6 beats (a=i*10, b=i, mode alternating), hold out_ready=0 for 3 cycles once out_valid rises -> in_ready low during the stall, outputs stable, all 6 results emerge in order with none lost or duplicated.
5. Bubbles and throughput: in_valid pattern 1,0,1,1 with out_ready=1 -> out_valid pattern 1,0,1,1 starting exactly 4 cycles later.
6. Reset mid-flight: accept 3 beats, assert rst asynchronously between edges -> out_valid and result go to 0 immediately. After release, no stale beat appears, and a new beat returns after 4 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor.
//   MODE_ADD / MODE_SUB : values of the per-beat mode bit.
//   chunk_lsb()         : bit index of the least significant bit of ripple
//                         chunk k when every chunk is cw bits wide.
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int chunk_lsb(input int k, input int cw);
        return k * cw;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CW-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b   [CW-1:0] in  : operand bits (b is already inverted for subtract)
//   ci              in  : carry into bit 0
//   sum    [CW-1:0] out : a + b + ci, truncated to CW bits
//   co              out : carry out of bit CW-1
//   c_msb           out : carry into bit CW-1 (signed-overflow input when
//                         this chunk holds the word's MSB)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] sum,
    output logic          co,
    output logic          c_msb
);

    // Each cell keeps its own carry nets so the chain is a set of distinct
    // signals rather than one vector feeding back into itself.
    for (genvar i = 0; i < CW; i++) begin : g_fa
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = ci;
        end else begin : g_rest
            assign c_in = g_fa[i-1].c_out;
        end

        assign sum[i] = a[i] ^ b[i] ^ c_in;
        assign c_out  = (a[i] & b[i]) | (c_in & (a[i] ^ b[i]));
    end

    assign co    = g_fa[CW-1].c_out;
    assign c_msb = g_fa[CW-1].c_in;

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
// WIDTH-bit two's-complement adder/subtractor split into STAGES ripple chunks,
// one chunk per pipeline stage, with the inter-chunk carry registered.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin, mode)
//   mode                : 0 = a + b + cin, 1 = a + ~b + cin
//   out_valid/out_ready : result handshake (result, cout, ovf)
//   result              : sum/difference modulo 2^WIDTH
//   cout                : carry out of the MSB (1 = no borrow when subtracting)
//   ovf                 : signed overflow (carry into MSB XOR carry out of MSB)
//
// Register layout: slot 0 captures the raw beat (a, b already conditioned by
// mode, cin). Stage k adds chunk k of slot k and writes slot k+1; the last
// stage writes the output registers. A beat accepted at edge N is therefore
// presented after edge N+STAGES. The whole pipe advances as one unit.
// -----------------------------------------------------------------------------
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // Guarded so an illegal STAGES reports the error below instead of a
    // divide-by-zero during elaboration.
    localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int CW          = WIDTH / STAGES_SAFE;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES_SAFE) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    // valid_q[k] : slot k holds a real beat; valid_q[STAGES] is out_valid.
    logic [STAGES:0]   valid_q, valid_d;

    // Operand skew registers: full words travel with the beat so every stage
    // can pick its own chunk; the low chunks are simply no longer consumed.
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];

    // Partial sum: in slot k, chunks 0..k-1 are final, the rest are zero.
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // Carry into chunk k, held in slot k.
    logic [STAGES-1:0] cy_q, cy_d;

    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // Chunk adder outputs.
    logic [CW-1:0]     chunk_sum [STAGES];
    logic [STAGES-1:0] chunk_co;
    logic              top_cmsb;

    logic              advance;

    // A full output slot that the consumer is not taking freezes everything,
    // including the input side.
    assign advance  = ~valid_q[STAGES] | out_ready;
    assign in_ready = advance;

    // -------------------------------------------------------------------------
    // Per-stage chunk adders
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LSB = chunk_lsb(k, CW);
        logic cm;

        addsub_chunk #(
            .CW (CW)
        ) u_chunk (
            .a     (opa_q[k][LSB +: CW]),
            .b     (opb_q[k][LSB +: CW]),
            .ci    (cy_q[k]),
            .sum   (chunk_sum[k]),
            .co    (chunk_co[k]),
            .c_msb (cm)
        );

        // Only the chunk that owns bit WIDTH-1 contributes to overflow.
        if (k == STAGES - 1) begin : g_top
            assign top_cmsb = cm;
        end else begin : g_mid
            logic cm_unused;
            assign cm_unused = cm;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path leaves a
        // variable unassigned; that is what keeps this block free of latches.
        valid_d  = valid_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        cy_d     = cy_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (advance) begin
            // Bubbles still move data; only the valid bits decide what counts.
            valid_d = {valid_q[STAGES-1:0], in_valid};

            // Slot 0: mode is folded into B here, so it travels with the beat.
            opa_d[0] = a;
            opb_d[0] = (mode == MODE_SUB) ? ~b : b;
            cy_d[0]  = cin;
            sum_d[0] = '0;

            for (int k = 1; k < STAGES; k++) begin
                opa_d[k] = opa_q[k-1];
                opb_d[k] = opb_q[k-1];
                cy_d[k]  = chunk_co[k-1];
                sum_d[k] = sum_q[k-1];
                sum_d[k][chunk_lsb(k-1, CW) +: CW] = chunk_sum[k-1];
            end

            result_d = sum_q[STAGES-1];
            result_d[chunk_lsb(STAGES-1, CW) +: CW] = chunk_sum[STAGES-1];
            cout_d   = chunk_co[STAGES-1];
            ovf_d    = top_cmsb ^ chunk_co[STAGES-1];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: datapath registers are reset along with the valid bits so that a
    // reset leaves result/cout/ovf at zero and no stale partial sum survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            cy_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            valid_q  <= valid_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sum_q    <= sum_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES];
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4). Expected
// results are pushed to a scoreboard queue when a beat is accepted and popped
// by an output monitor when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             co;
        logic             ov;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   n_out  = 0;

    pipelined_addsub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain WIDTH+1-bit arithmetic, overflow from the sign rule.
    function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                   input logic c_i, input logic m_i);
        logic [WIDTH-1:0] bp;
        logic [WIDTH:0]   full;
        exp_t             e;
        bp   = m_i ? ~b_i : b_i;
        full = {1'b0, a_i} + {1'b0, bp} + {{WIDTH{1'b0}}, c_i};
        e.r  = full[WIDTH-1:0];
        e.co = full[WIDTH];
        e.ov = (a_i[WIDTH-1] == bp[WIDTH-1]) && (e.r[WIDTH-1] != a_i[WIDTH-1]);
        return e;
    endfunction

    // Output monitor / scoreboard: a result is consumed on the edge after a
    // falling edge where out_valid & out_ready hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got result=%h cout=%b ovf=%b, required no output",
                         result, cout, ovf);
            end else begin
                e = sb.pop_front();
                n_out++;
                if ({result, cout, ovf} !== {e.r, e.co, e.ov})
                    $display("FAIL result_beat%0d: got result=%h cout=%b ovf=%b, required result=%h cout=%b ovf=%b",
                             n_out, result, cout, ovf, e.r, e.co, e.ov);
                else
                    passed++;
            end
        end
    end

    // Drive one beat from posedge+1 and hold it until accepted.
    task automatic send(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                        input logic c_i, input logic m_i, input exp_t e);
        bit done;
        done     = 1'b0;
        a        = a_i;
        b        = b_i;
        cin      = c_i;
        mode     = m_i;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            if (done) sb.push_back(e);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: got in_ready=0 for 40 cycles, required acceptance");
        end
    endtask

    // After a send returns (accept edge N, +1), out_valid must rise after N+4.
    task automatic expect_latency(input string name);
        for (int i = 1; i <= STAGES; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'(i == STAGES))
                $display("FAIL %s_latency_edge%0d: got out_valid=%b, required %b",
                         name, i, out_valid, 1'(i == STAGES));
            else
                passed++;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0)
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, result, cout, ovf} !== '0)
            $display("FAIL reset_outputs: got out_valid=%b result=%h cout=%b ovf=%b, required all 0",
                     out_valid, result, cout, ovf);
        else
            passed++;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, MODE_ADD, '{32'h0000_0100, 1'b0, 1'b0});
        expect_latency("add_ff");
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, '{32'h0000_0000, 1'b1, 1'b0});
        drain();
    endtask

    task automatic test_sub();
        send(32'd100, 32'd20, 1'b1, MODE_SUB, '{32'd80, 1'b1, 1'b0});
        send(32'd5, 32'd7, 1'b1, MODE_SUB, '{32'hFFFF_FFFE, 1'b0, 1'b0});
        // cin = 0 gives a - b - 1
        send(32'd10, 32'd3, 1'b0, MODE_SUB, '{32'd6, 1'b1, 1'b0});
        drain();
    endtask

    task automatic test_overflow();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, '{32'h8000_0000, 1'b0, 1'b1});
        send(32'h8000_0000, 32'h0000_0001, 1'b1, MODE_SUB, '{32'h7FFF_FFFF, 1'b1, 1'b1});
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic m;
                    m = 1'(i % 2);
                    send(32'(i * 10), 32'(i), m, m, model(32'(i * 10), 32'(i), m, m));
                end
            end
            begin
                int t;
                logic [WIDTH-1:0] hold_r;
                logic             hold_c;
                logic             hold_o;
                t = 0;
                while (out_valid !== 1'b1 && t < 40) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                if (t >= 40) begin
                    checks++;
                    $display("FAIL stall_wait: got out_valid=0 for 40 cycles, required 1");
                end
                out_ready = 1'b0;
                hold_r    = result;
                hold_c    = cout;
                hold_o    = ovf;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1)
                        $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, required 0 1",
                                 in_ready, out_valid);
                    else
                        passed++;
                    checks++;
                    if ({result, cout, ovf} !== {hold_r, hold_c, hold_o})
                        $display("FAIL stall_hold: got result=%h cout=%b ovf=%b, required result=%h cout=%b ovf=%b",
                                 result, cout, ovf, hold_r, hold_c, hold_o);
                    else
                        passed++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_out - base != 6)
            $display("FAIL stream_count: got %0d results, required 6", n_out - base);
        else
            passed++;
    endtask

    task automatic test_bubbles();
        logic [3:0] pat;
        pat = 4'b1101;  // bit i = in_valid in cycle i: 1,0,1,1
        for (int i = 0; i < 4; i++) begin
            a        = 32'h0100_0000 * 32'(i + 1);
            b        = 32'(i + 3);
            cin      = 1'b0;
            mode     = MODE_ADD;
            in_valid = pat[i];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1)
                $display("FAIL bubble_in_ready%0d: got %b, required 1", i, in_ready);
            else
                passed++;
            @(posedge clk);
            if (pat[i]) sb.push_back(model(a, b, cin, mode));
            #1;
        end
        in_valid = 1'b0;
        // Edges N+1..N+3 have passed; outputs show up at N+4..N+7.
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL bubble_early: got out_valid=%b, required 0", out_valid);
        else
            passed++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== pat[i])
                $display("FAIL bubble_pattern%0d: got out_valid=%b, required %b", i, out_valid, pat[i]);
            else
                passed++;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int t;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h1234_5678 + 32'(i), 32'h0000_1111, 1'b0, MODE_ADD,
                 model(32'h1234_5678 + 32'(i), 32'h0000_1111, 1'b0, MODE_ADD));
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (out_valid !== 1'b1)
            $display("FAIL midflight_fill: got out_valid=%b, required 1", out_valid);
        else
            passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, cout, ovf} !== '0)
            $display("FAIL midflight_reset: got out_valid=%b result=%h cout=%b ovf=%b, required all 0",
                     out_valid, result, cout, ovf);
        else
            passed++;
        sb.delete();
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0)
                $display("FAIL stale_beat%0d: got out_valid=%b, required 0", i, out_valid);
            else
                passed++;
        end
        send(32'hCAFE_0000, 32'h0000_BEEF, 1'b1, MODE_SUB,
             model(32'hCAFE_0000, 32'h0000_BEEF, 1'b1, MODE_SUB));
        expect_latency("post_reset");
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        mode      = MODE_ADD;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_bubbles();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
